psx_guitar_responder: RTL

- Console-facing end of the player path: takes the fret, strum, whammy and tilt outputs of the player block and answers PlayStation-2 controller-port polls as a Guitar Hero guitar.
- The console is the initiator and this block is the responder.
- Samples the port pins in the system CLK domain, decodes the poll command and shifts out a coherent snapshot of controller state.
- Generates ACK pulses between bytes.

---
 rtl/psx_guitar_responder_if.sv | 25 ++
 rtl/psx_guitar_responder.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/psx_guitar_responder_if.sv
// PlayStation controller-port pin bundle: console drives ATT/CLK/CMD,
// the responder answers on open-drain DAT and ACK (modelled as pull-low enables).
interface psx_guitar_responder_if;
  logic PsxAtt;
  logic PsxClk;
  logic PsxCmd;
  logic DatLow;
  logic AckLow;

  modport master (
    output PsxAtt,
    output PsxClk,
    output PsxCmd,
    input  DatLow,
    input  AckLow
  );

  modport slave (
    input  PsxAtt,
    input  PsxClk,
    input  PsxCmd,
    output DatLow,
    output AckLow
  );
endinterface

// File: rtl/psx_guitar_responder.sv
// Answers PS2 controller-port polls as a Guitar Hero guitar: synchronises the
// port pins, shifts out a snapshot taken at ATT fall and pulses ACK between bytes.
module psx_guitar_responder #(
  parameter int ANALOG    = 1,
  parameter int ACK_DELAY = 8,
  parameter int ACK_WIDTH = 200
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 Enable,
  input  logic [4:0]           Frets,
  input  logic                 Strum,
  input  logic [7:0]           Whammy,
  input  logic                 Tilt,
  psx_guitar_responder_if.slave psx,
  output logic [7:0]           PollCount,
  output logic [2:0]           Status
);

  localparam logic [3:0] LAST    = (ANALOG != 0) ? 4'd8 : 4'd4;
  localparam logic [7:0] ID_BYTE = (ANALOG != 0) ? 8'h73 : 8'h41;
  localparam int CNT_MAX = (ACK_DELAY > ACK_WIDTH) ? ACK_DELAY : ACK_WIDTH;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SHIFT,
    S_ACK_WAIT,
    S_ACK_PULSE,
    S_DONE,
    S_IGNORE
  } state_t;

  function automatic logic [7:0] reply_byte(input logic [3:0] idx,
                                            input logic [7:0] b3,
                                            input logic [7:0] b4,
                                            input logic [7:0] rx);
    case (idx)
      4'd0:    reply_byte = 8'hFF;
      4'd1:    reply_byte = ID_BYTE;
      4'd2:    reply_byte = 8'h5A;
      4'd3:    reply_byte = b3;
      4'd4:    reply_byte = b4;
      4'd5:    reply_byte = rx;
      default: reply_byte = 8'h80;
    endcase
  endfunction

  logic r_att_s1, r_att_s2, r_att_s3;
  logic r_clk_s1, r_clk_s2, r_clk_s3;
  logic r_cmd_s1, r_cmd_s2;

  state_t           r_state, w_state_nx;
  logic [3:0]       r_byte, w_byte_nx;
  logic [2:0]       r_bit, w_bit_nx;
  logic [CNT_W-1:0] r_cnt, w_cnt_nx;
  logic             r_dat, w_dat_nx;
  logic             r_ack, w_ack_nx;
  logic [7:0]       r_poll, w_poll_nx;
  logic             r_err, w_err_nx;
  logic             w_snap, w_shift_in;

  logic [7:0] r_byte3, r_byte4, r_rx;
  logic [6:0] r_cmd_sh;

  logic       w_att_fall, w_att_rise, w_clk_fall, w_clk_rise;
  logic [7:0] w_cmd_byte, w_reply_cur, w_reply_next;
  logic [7:0] w_byte3_in, w_byte4_in, w_rx_in;
  logic [3:0] w_byte_inc;

  // Stage 0: pin synchronisers plus one delay flop for edge detection
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_att_s1 <= 1'b1; r_att_s2 <= 1'b1; r_att_s3 <= 1'b1;
      r_clk_s1 <= 1'b1; r_clk_s2 <= 1'b1; r_clk_s3 <= 1'b1;
      r_cmd_s1 <= 1'b1; r_cmd_s2 <= 1'b1;
    end else begin
      r_att_s1 <= psx.PsxAtt; r_att_s2 <= r_att_s1; r_att_s3 <= r_att_s2;
      r_clk_s1 <= psx.PsxClk; r_clk_s2 <= r_clk_s1; r_clk_s3 <= r_clk_s2;
      r_cmd_s1 <= psx.PsxCmd; r_cmd_s2 <= r_cmd_s1;
    end
  end

  assign w_att_fall = r_att_s3 & ~r_att_s2;
  assign w_att_rise = ~r_att_s3 & r_att_s2;
  assign w_clk_fall = r_clk_s3 & ~r_clk_s2;
  assign w_clk_rise = ~r_clk_s3 & r_clk_s2;

  // Button bytes are active low; a disabled guitar reports everything released
  always_comb begin
    w_byte3_in = 8'hFF;
    w_byte4_in = 8'hFF;
    w_rx_in    = 8'h80;
    if (Enable) begin
      w_byte3_in[0] = ~Tilt;
      w_byte3_in[6] = ~Strum;
      w_byte4_in[1] = ~Frets[0];
      w_byte4_in[5] = ~Frets[1];
      w_byte4_in[4] = ~Frets[2];
      w_byte4_in[6] = ~Frets[3];
      w_byte4_in[7] = ~Frets[4];
      w_rx_in       = 8'h80 ^ Whammy;
    end
  end

  // Stage 1: snapshot and command shift register (data only, no reset)
  always_ff @(posedge CLK) begin
    if (w_snap) begin
      r_byte3 <= w_byte3_in;
      r_byte4 <= w_byte4_in;
      r_rx    <= w_rx_in;
    end
    if (w_shift_in)
      r_cmd_sh <= {r_cmd_s2, r_cmd_sh[6:1]};
  end

  assign w_cmd_byte   = {r_cmd_s2, r_cmd_sh};
  assign w_byte_inc   = r_byte + 4'd1;
  assign w_reply_cur  = reply_byte(r_byte, r_byte3, r_byte4, r_rx);
  assign w_reply_next = reply_byte(w_byte_inc, r_byte3, r_byte4, r_rx);

  always_comb begin
    w_state_nx = r_state;
    w_byte_nx  = r_byte;
    w_bit_nx   = r_bit;
    w_cnt_nx   = r_cnt;
    w_dat_nx   = r_dat;
    w_ack_nx   = r_ack;
    w_poll_nx  = r_poll;
    w_err_nx   = r_err;
    w_snap     = 1'b0;
    w_shift_in = 1'b0;
    if (w_att_rise) begin
      w_state_nx = S_IDLE;
      w_dat_nx   = 1'b0;
      w_ack_nx   = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_dat_nx = 1'b0;
          w_ack_nx = 1'b0;
          if (w_att_fall) begin
            w_state_nx = S_SHIFT;
            w_byte_nx  = 4'd0;
            w_bit_nx   = 3'd0;
            w_snap     = 1'b1;
          end
        end
        S_SHIFT: begin
          if (w_clk_fall) begin
            w_dat_nx = ~w_reply_cur[r_bit];
          end else if (w_clk_rise) begin
            w_shift_in = 1'b1;
            w_bit_nx   = r_bit + 3'd1;
            if (r_bit == 3'd7) begin
              if (r_byte == 4'd0 && w_cmd_byte != 8'h01) begin
                w_state_nx = S_IGNORE;
                w_dat_nx   = 1'b0;
              end else if (r_byte == 4'd1 && w_cmd_byte != 8'h42) begin
                w_state_nx = S_IGNORE;
                w_dat_nx   = 1'b0;
                w_err_nx   = 1'b1;
              end else if (r_byte == LAST) begin
                w_state_nx = S_DONE;
                w_dat_nx   = 1'b0;
                w_poll_nx  = r_poll + 8'd1;
                w_err_nx   = 1'b0;
              end else begin
                w_state_nx = S_ACK_WAIT;
                w_cnt_nx   = '0;
              end
            end
          end
        end
        S_ACK_WAIT, S_ACK_PULSE: begin
          // An early console clock cancels the ACK and starts the next byte
          if (w_clk_fall) begin
            w_state_nx = S_SHIFT;
            w_ack_nx   = 1'b0;
            w_byte_nx  = w_byte_inc;
            w_bit_nx   = 3'd0;
            w_dat_nx   = ~w_reply_next[0];
          end else if (r_state == S_ACK_WAIT) begin
            if (r_cnt == CNT_W'(ACK_DELAY - 1)) begin
              w_state_nx = S_ACK_PULSE;
              w_dat_nx   = 1'b0;
              w_ack_nx   = 1'b1;
              w_cnt_nx   = '0;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end else begin
            if (r_cnt == CNT_W'(ACK_WIDTH - 1)) begin
              w_state_nx = S_SHIFT;
              w_ack_nx   = 1'b0;
              w_byte_nx  = w_byte_inc;
              w_bit_nx   = 3'd0;
            end else begin
              w_cnt_nx = r_cnt + 1'b1;
            end
          end
        end
        default: begin
          w_dat_nx = 1'b0;
          w_ack_nx = 1'b0;
        end
      endcase
    end
  end

  // Stage 2: control registers
  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      r_state <= S_IDLE;
      r_byte  <= 4'd0;
      r_bit   <= 3'd0;
      r_cnt   <= '0;
      r_dat   <= 1'b0;
      r_ack   <= 1'b0;
      r_poll  <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_byte  <= w_byte_nx;
      r_bit   <= w_bit_nx;
      r_cnt   <= w_cnt_nx;
      r_dat   <= w_dat_nx;
      r_ack   <= w_ack_nx;
      r_poll  <= w_poll_nx;
      r_err   <= w_err_nx;
    end
  end

  assign psx.DatLow = r_dat;
  assign psx.AckLow = r_ack;
  assign PollCount  = r_poll;
  assign Status     = {r_state == S_IGNORE, r_state != S_IDLE, r_err};

endmodule
